// File: rtl/irq_sequencer.sv
// irq_sequencer: timed interrupt and mtimecmp stimulus for SoC bring-up; define IRQ_SEQ_PULSE_EN for pulsed irq lines
module irq_sequencer #(
  parameter int          NUM_CH      = 3,
  parameter int          CNT_W       = 32,
  parameter int          TIMEOUT_CYC = 1000,
  parameter logic [63:0] MTCMP_VAL   = 64'd15,
  parameter int          MTCMP_START = 100,
  parameter int          MTCMP_LEN   = 100
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_start,
  input  logic [NUM_CH*CNT_W-1:0] i_fire_cyc,
  input  logic                    i_trap_taken,
  output logic [NUM_CH-1:0]       o_irq,
  output logic                    o_mtimecmp_wr,
  output logic [63:0]             o_mtimecmp_din,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_err_order,
  output logic                    o_err_timeout,
  output logic [2:0]              o_err_ch
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE, ERR} gst_e;
  typedef enum logic [1:0] {WAIT, ASSERT, ACKED} cst_e;
  gst_e                    st_q;
  cst_e                    ch_q [NUM_CH];
  logic [TW-1:0]           tmo_q [NUM_CH];
  logic [CNT_W-1:0]        cyc_q, cyc_d;
  logic [NUM_CH*CNT_W-1:0] fire_q;
  logic [NUM_CH-1:0]       ack, hit, ord_err, tmo_err;
  logic [63:0]             cw_d;
  logic                    wr_d, burst_done, all_acked, seen, prev_ok;
  logic [2:0]              ord_ch, tmo_ch;
  // Per-channel firing, acknowledge routing, error detection and burst window
  always_comb begin
    cyc_d = (st_q == IDLE) ? '0 : (&cyc_q ? cyc_q : cyc_q + 1'b1);
    cw_d = 64'(cyc_d);
    wr_d = (MTCMP_LEN != 0) && cw_d >= 64'(MTCMP_START) && cw_d < 64'(MTCMP_START) + 64'(MTCMP_LEN);
    burst_done = (MTCMP_LEN == 0) || 64'(cyc_q) >= 64'(MTCMP_START) + 64'(MTCMP_LEN);
    ack = '0;
    hit = '0;
    ord_err = '0;
    tmo_err = '0;
    seen = 1'b0;
    prev_ok = 1'b1;
    all_acked = 1'b1;
    for (int k = 0; k < NUM_CH; k++) begin
      ack[k] = i_trap_taken && ch_q[k] == ASSERT && !seen;
      seen = seen || ch_q[k] == ASSERT;
      hit[k] = ch_q[k] == WAIT && cyc_q == fire_q[k*CNT_W +: CNT_W];
      ord_err[k] = hit[k] && !prev_ok;
      tmo_err[k] = ch_q[k] == ASSERT && !ack[k] && tmo_q[k] == TW'(TIMEOUT_CYC - 1);
      prev_ok = ch_q[k] == ACKED || ack[k];
      all_acked = all_acked && ch_q[k] == ACKED;
    end
    ord_ch = '0;
    tmo_ch = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      ord_ch = ord_err[k] ? 3'(k) : ord_ch;
      tmo_ch = tmo_err[k] ? 3'(k) : tmo_ch;
    end
  end
  // Global sequencer FSM with registered outputs; errors take priority over completion
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      st_q <= IDLE;
      cyc_q <= '0;
      fire_q <= '0;
      o_irq <= '0;
      o_mtimecmp_wr <= 1'b0;
      o_mtimecmp_din <= '0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
      o_err_order <= 1'b0;
      o_err_timeout <= 1'b0;
      o_err_ch <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        ch_q[k] <= WAIT;
        tmo_q[k] <= '0;
      end
    end else begin
      case (st_q)
        IDLE: if (i_start) begin
          st_q <= RUN;
          cyc_q <= '0;
          fire_q <= i_fire_cyc;
          o_busy <= 1'b1;
          o_mtimecmp_wr <= wr_d;
          o_mtimecmp_din <= wr_d ? MTCMP_VAL : '0;
          for (int k = 0; k < NUM_CH; k++) begin
            ch_q[k] <= (i_fire_cyc[k*CNT_W +: CNT_W] == '0) ? ACKED : WAIT;
            tmo_q[k] <= '0;
          end
        end
        RUN: begin
          cyc_q <= cyc_d;
          if (|ord_err || |tmo_err) begin
            st_q <= ERR;
            o_err_order <= |ord_err;
            o_err_timeout <= !(|ord_err);
            o_err_ch <= |ord_err ? ord_ch : tmo_ch;
            o_irq <= '0;
            o_mtimecmp_wr <= 1'b0;
            o_mtimecmp_din <= '0;
            o_busy <= 1'b0;
          end else if (all_acked && burst_done) begin
            st_q <= DONE;
            o_done <= 1'b1;
            o_busy <= 1'b0;
            o_mtimecmp_wr <= 1'b0;
            o_mtimecmp_din <= '0;
          end else begin
            o_mtimecmp_wr <= wr_d;
            o_mtimecmp_din <= wr_d ? MTCMP_VAL : '0;
            for (int k = 0; k < NUM_CH; k++)
              if (hit[k]) begin
                ch_q[k] <= ASSERT;
                tmo_q[k] <= '0;
                o_irq[k] <= 1'b1;
              end else if (ack[k]) begin
                ch_q[k] <= ACKED;
                o_irq[k] <= 1'b0;
              end else begin
                if (ch_q[k] == ASSERT) tmo_q[k] <= tmo_q[k] + 1'b1;
`ifdef IRQ_SEQ_PULSE_EN
                o_irq[k] <= 1'b0;
`endif
              end
          end
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_irq_sequencer.sv
// tb_irq_sequencer: directed checks of firing order, acknowledge, errors, mtimecmp burst and reset abort
module tb_irq_sequencer;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, trap = 1'b0;
  logic [95:0] fire = '0;
  logic [2:0]  irq, ech;
  logic        wr, busy, done, eo, et;
  logic [63:0] din;
  int          checks = 0, fails = 0, cur = 0;

  irq_sequencer dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_fire_cyc(fire), .i_trap_taken(trap),
    .o_irq(irq), .o_mtimecmp_wr(wr), .o_mtimecmp_din(din), .o_busy(busy), .o_done(done),
    .o_err_order(eo), .o_err_timeout(et), .o_err_ch(ech)
  );

  always #5 clk = ~clk;

  // cur tracks the value of the DUT cycle counter at each falling edge
  task automatic go_to(input int n);
    while (cur < n) begin
      @(negedge clk);
      cur++;
    end
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0;
    trap = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic launch(input logic [95:0] f);
    @(negedge clk);
    fire = f;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cur = 0;
  endtask

  task automatic test_reset;
    do_reset();
    checks++; if ({irq, wr, busy, done, eo, et, ech} !== 11'b0) begin fails++; $display("FAIL reset_flags: got %b want 0", {irq, wr, busy, done, eo, et, ech}); end
    checks++; if (din !== 64'd0) begin fails++; $display("FAIL reset_din: got %0d want 0", din); end
  endtask

  task automatic test_mtimecmp_burst;
    go_to(99);
    checks++; if (wr !== 1'b0 || din !== 64'd0) begin fails++; $display("FAIL burst_pre: got wr=%b din=%0d want 0/0", wr, din); end
    go_to(100);
    checks++; if (wr !== 1'b1 || din !== 64'd15) begin fails++; $display("FAIL burst_first: got wr=%b din=%0d want 1/15", wr, din); end
    go_to(199);
    checks++; if (wr !== 1'b1 || din !== 64'd15) begin fails++; $display("FAIL burst_last: got wr=%b din=%0d want 1/15", wr, din); end
    go_to(200);
    checks++; if (wr !== 1'b0 || din !== 64'd0) begin fails++; $display("FAIL burst_post: got wr=%b din=%0d want 0/0", wr, din); end
  endtask

  task automatic test_in_order;
    launch({32'd15000, 32'd10000, 32'd5000});
    checks++; if (busy !== 1'b1 || irq !== 3'b000) begin fails++; $display("FAIL run_start: got busy=%b irq=%b want 1/000", busy, irq); end
    test_mtimecmp_burst();
    for (int k = 0; k < 3; k++) begin
      int off;
      logic [2:0] exp;
      off = (k + 1) * 5000;
      exp = 3'b001 << k;
      go_to(off);
      checks++; if (irq !== 3'b000) begin fails++; $display("FAIL ch%0d_before: got %b want 000", k, irq); end
      go_to(off + 1);
      checks++; if (irq !== exp) begin fails++; $display("FAIL ch%0d_rise: got %b want %b", k, irq, exp); end
      go_to(off + 20);
      checks++; if (irq !== exp) begin fails++; $display("FAIL ch%0d_hold: got %b want %b", k, irq, exp); end
      trap = 1'b1;
      go_to(off + 21);
      trap = 1'b0;
      checks++; if (irq !== 3'b000) begin fails++; $display("FAIL ch%0d_fall: got %b want 000", k, irq); end
    end
    go_to(15022);
    checks++; if (done !== 1'b1 || busy !== 1'b0 || eo !== 1'b0 || et !== 1'b0) begin fails++; $display("FAIL in_order_done: got done=%b busy=%b eo=%b et=%b want 1/0/0/0", done, busy, eo, et); end
  endtask

  task automatic test_start_ignored;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (done !== 1'b1 || busy !== 1'b0 || irq !== 3'b000) begin fails++; $display("FAIL start_in_done: got done=%b busy=%b irq=%b want 1/0/000", done, busy, irq); end
  endtask

  task automatic test_order_err;
    do_reset();
    launch({32'd0, 32'd150, 32'd100});
    go_to(101);
    checks++; if (irq !== 3'b001) begin fails++; $display("FAIL order_ch0_rise: got %b want 001", irq); end
    go_to(150);
    checks++; if (eo !== 1'b0 || wr !== 1'b1) begin fails++; $display("FAIL order_pre: got eo=%b wr=%b want 0/1", eo, wr); end
    go_to(151);
    checks++; if (eo !== 1'b1 || et !== 1'b0 || ech !== 3'd1) begin fails++; $display("FAIL order_flag: got eo=%b et=%b ch=%0d want 1/0/1", eo, et, ech); end
    checks++; if (irq !== 3'b000 || wr !== 1'b0 || din !== 64'd0 || busy !== 1'b0) begin fails++; $display("FAIL order_outs: got irq=%b wr=%b din=%0d busy=%b want 0", irq, wr, din, busy); end
  endtask

  task automatic test_timeout;
    do_reset();
    launch({32'd0, 32'd0, 32'd100});
    go_to(1100);
    checks++; if (et !== 1'b0 || irq !== 3'b001) begin fails++; $display("FAIL tmo_pre: got et=%b irq=%b want 0/001", et, irq); end
    go_to(1101);
    checks++; if (et !== 1'b1 || eo !== 1'b0 || ech !== 3'd0 || irq !== 3'b000) begin fails++; $display("FAIL tmo_flag: got et=%b eo=%b ch=%0d irq=%b want 1/0/0/000", et, eo, ech, irq); end
    go_to(1110);
    trap = 1'b1;
    go_to(1112);
    trap = 1'b0;
    checks++; if (et !== 1'b1 || done !== 1'b0) begin fails++; $display("FAIL tmo_sticky: got et=%b done=%b want 1/0", et, done); end
  endtask

  task automatic test_ack_same_cycle;
    do_reset();
    launch({32'd0, 32'd120, 32'd100});
    go_to(50);
    trap = 1'b1;
    go_to(51);
    trap = 1'b0;
    go_to(101);
    checks++; if (irq !== 3'b001) begin fails++; $display("FAIL stray_ack: got %b want 001", irq); end
    go_to(120);
    trap = 1'b1;
    go_to(121);
    trap = 1'b0;
    checks++; if (irq !== 3'b010 || eo !== 1'b0) begin fails++; $display("FAIL same_cycle_ack: got irq=%b eo=%b want 010/0", irq, eo); end
    go_to(130);
    trap = 1'b1;
    go_to(131);
    trap = 1'b0;
    checks++; if (irq !== 3'b000) begin fails++; $display("FAIL ch1_ack: got %b want 000", irq); end
    go_to(200);
    checks++; if (done !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL done_wait_burst: got done=%b busy=%b want 0/1", done, busy); end
    go_to(201);
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL done_after_burst: got done=%b busy=%b want 1/0", done, busy); end
  endtask

  task automatic test_reset_mid;
    do_reset();
    launch({32'd15000, 32'd10000, 32'd5000});
    go_to(5020);
    trap = 1'b1;
    go_to(5021);
    trap = 1'b0;
    go_to(10010);
    checks++; if (irq !== 3'b010 || busy !== 1'b1) begin fails++; $display("FAIL mid_pre: got irq=%b busy=%b want 010/1", irq, busy); end
    rst_n = 1'b0;
    #1;
    checks++; if ({irq, wr, busy, done, eo, et, ech} !== 11'b0 || din !== 64'd0) begin fails++; $display("FAIL mid_abort: got %b din=%0d want 0", {irq, wr, busy, done, eo, et, ech}, din); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    test_in_order();
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_start_ignored();
    test_order_err();
    test_timeout();
    test_ack_same_cycle();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end
endmodule
